// File: rtl/uart_pkg.sv
// Shared types and register map for the UART transmit controller.
// No logic, so no latency of its own.
// No flow control of its own; used by uart_tx_ctrl and uart_tx_fifo.
package uart_pkg;

  // Serialiser states: one start bit, eight data bits, one stop bit
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Word offsets within the UART window
  localparam logic [1:0] TXDATA   = 2'd0;
  localparam logic [1:0] BAUD_DIV = 2'd1;
  localparam logic [1:0] STATUS   = 2'd2;
  localparam logic [1:0] CTRL     = 2'd3;

  // STATUS bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_CNT_LSB = 4;

  // CTRL bit positions
  localparam int CTRL_IRQ_EN  = 0;

  // Assemble the STATUS word; unlisted bits read as zero
  function automatic logic [31:0] pack_status(input logic busy, input logic full,
                                              input logic empty, input logic [3:0] cnt);
    logic [31:0] s;
    s = 32'd0;
    s[STAT_BUSY]                  = busy;
    s[STAT_FULL]                  = full;
    s[STAT_EMPTY]                 = empty;
    s[STAT_CNT_LSB+3:STAT_CNT_LSB] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO holding stored TX bytes ahead of the serialiser.
// Push visible on the next edge; dout shows the head combinationally.
// Push while full and pop while empty are dropped; the caller stalls on full.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage array; no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO; optional TX-empty irq under UART_TX_IRQ_EN.
// First start bit drives tx one cycle after the store edge; rdata is combinational.
// stallMW holds a TXDATA store while the registered FIFO-full flag is set.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int               FIFO_DEPTH  = 4,
  parameter int               DIV_W       = 16,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(867)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_select,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stallMW,
  output logic        tx,
  output logic        irq_tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t        state_q, state_d;
  logic [DIV_W-1:0] baud_div;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             bit_end;

  logic             push_req;
  logic             push;
  logic             pop;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [31:0]      ctrl_rd;
  logic             unused_wdata;

  assign unused_wdata = &{1'b0, wdata};

  // Stall decision uses the registered full flag only, so a same-cycle pop
  // does not let the store in; it lands on the edge after full drops.
  assign push_req = uart_select & wr_en & (addr == TXDATA);
  assign push     = push_req & ~fifo_full;
  assign stallMW  = push_req & fifo_full;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Baud divisor register; a write mid-frame is picked up at the next bit reload
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_div <= DEFAULT_DIV;
    end else if (uart_select && wr_en && addr == BAUD_DIV) begin
      baud_div <= wdata[DIV_W-1:0];
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_en;
  logic irq_q;

  // CTRL register: only the interrupt enable is implemented
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en <= 1'b0;
    end else if (uart_select && wr_en && addr == CTRL) begin
      irq_en <= wdata[CTRL_IRQ_EN];
    end
  end

  // TX-empty interrupt, registered so it rises one cycle after the line goes idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_en & fifo_empty & (state_q == IDLE);
    end
  end

  assign irq_tx  = irq_q;
  assign ctrl_rd = 32'(irq_en) << CTRL_IRQ_EN;
`else
  assign irq_tx  = 1'b0;
  assign ctrl_rd = 32'd0;
`endif

  // Serialiser state, baud counter, bit index and shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Next-state: every bit reloads the divisor and lasts until the counter hits zero;
  // the FIFO head is popped straight into the shifter so frames run back to back
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    bit_end = (cnt_q == '0);
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          cnt_d   = baud_div;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = baud_div;
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = baud_div;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            cnt_d   = baud_div;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line driver decoded from registered state, so reset forces it high at once
  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

  // Load data mux; anything other than a selected load reads zero
  always_comb begin
    rdata = 32'd0;
    if (uart_select && rd_en) begin
      case (addr)
        BAUD_DIV: rdata = 32'(baud_div);
        STATUS:   rdata = pack_status(state_q != IDLE, fifo_full, fifo_empty,
                                      4'(fifo_count));
        CTRL:     rdata = ctrl_rd;
        default:  rdata = 32'd0;
      endcase
    end
  end

endmodule
